scpu_ctrl_pipe: RTL and testbench
=================================

Name: scpu_ctrl_pipe

Overview:
Consumer end of the ID-stage control bundles (id_ex / id_m / id_wb) that the instruction decoder produces.
- Registers the bundles, plus destination/source register numbers, through the ID/EX, EX/MEM and MEM/WB pipeline stages.
- Detects load-use hazards and inserts bubbles.
- Resolves beq/bne in EX and flushes wrong-path work.
- Generates EX-stage operand forwarding selects.
- Sits between the decoder and the datapath pipeline registers.

Parameters:
RA_W, 5, register-address width
EX_W, 5, EX bundle width: bit4 alu_src_b, bits3:0 alu_op
M_W, 3, MEM bundle width: bit2 branch, bit1 b_type (1=beq, 0=bne), bit0 mem_write
WB_W, 4, WB bundle width: bit3 reserved (0), bit2 reg_write, bits1:0 mem_to_reg (00 alu, 01 imm, 10 pc+4, 11 load)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_ex  in  EX_W  decoder EX bundle
id_m  in  M_W  decoder MEM bundle
id_wb  in  WB_W  decoder WB bundle
id_rs1  in  RA_W  source 1
id_rs2  in  RA_W  source 2
id_rd  in  RA_W  destination
ex_zero  in  1  ALU zero flag of the instruction in EX
ex_ctrl_ex  out  EX_W  ID/EX EX bundle
ex_ctrl_m  out  M_W  ID/EX MEM bundle
ex_ctrl_wb  out  WB_W  ID/EX WB bundle
ex_rd  out  RA_W  ID/EX destination
mem_ctrl_m  out  M_W  EX/MEM MEM bundle
mem_ctrl_wb  out  WB_W  EX/MEM WB bundle
mem_rd  out  RA_W  EX/MEM destination
wb_ctrl_wb  out  WB_W  MEM/WB WB bundle
wb_rd  out  RA_W  MEM/WB destination
stall_if_id  out  1  hold PC and IF/ID (combinational)
flush_if_id  out  1  squash IF/ID (combinational)
pc_redirect  out  1  branch taken in EX; PC loads the branch target (combinational)
fwd_a  out  2  rs1 operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  rs2 operand select, same encoding

Behaviour:
- Reset: rst_n=0 sampled at a clk edge clears every stage register (bundles, rd, rs1/rs2, valid) to 0, so all registered outputs read 0.
  - A zero bundle is a bubble: no reg_write, no mem_write, no branch.
  - Reset mid-operation discards all in-flight instructions; there is no partial state.
- Advance: each cycle MEM/WB<-EX/MEM and EX/MEM<-ID/EX unconditionally; there is no back-pressure from MEM/WB.
- Latency: a bundle accepted in ID appears at ex_* 1 cycle later, mem_* after 2 cycles, wb_* after 3.
- Internal stage signals: ex_rs1, ex_rs2, ex_valid live in ID/EX.
- Load-use hazard (combinational), all conditions true:
  - ex_valid, ex_ctrl_wb[1:0]==11, ex_rd!=0;
  - and one of:
    - ex_rd==id_rs1;
    - ex_rd==id_rs2 with id_ex[4]==0 (register operand) or id_m[0]==1 (store data).
- Taken branch: take = ex_valid & ex_ctrl_m[2] & (ex_zero == ex_ctrl_m[1]).
- Priority and outcome:
  - take=1 -> pc_redirect=1, flush_if_id=1, stall_if_id=0; ID/EX loads a bubble (the wrong-path ID instruction is dropped). take overrides a simultaneous load-use hazard.
  - else load-use -> stall_if_id=1; ID/EX loads a bubble; the ID instruction is re-presented next cycle.
  - else ID/EX loads the id_* inputs, gated by id_valid (id_valid=0 loads a bubble).
- Forwarding for fwd_a (fwd_b is identical with ex_rs2):
  - 10 if mem_ctrl_wb[2] & mem_rd!=0 & mem_rd==ex_rs1;
  - else 01 if wb_ctrl_wb[2] & wb_rd!=0 & wb_rd==ex_rs1;
  - else 00.
  - EX/MEM wins when both stages match.
  - x0 is never forwarded.
- Bundle bits are passed through verbatim and never interpreted beyond the rules above; bit3 of the WB bundle is carried unchanged.

Decomposition:
- Shared package scpu_ctrl_pkg holds:
  - the EX_W/M_W/WB_W widths;
  - the bit-index constants (ALU_SRC_B, BRANCH, B_TYPE, MEM_WRITE, REG_WRITE);
  - the MEM_TO_REG_* codes (ALU, IMM, PC4, LOAD);
  - the FWD_* codes.
- The decoder imports the same package.
- One sub-module, scpu_fwd_unit: the purely combinational forwarding compare, instantiated once per operand.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 and non-zero bundles -> all ex_/mem_/wb_ outputs are 0; stall, flush, redirect and fwd are 0.
- Pipeline flow: one addi (id_ex=5'b10000, id_wb=4'b0100, rd=5) then idle -> ex_rd=5 at +1, mem_rd=5 at +2, wb_ctrl_wb=0100 at +3, then zeros.
- Load-use: lw rd=3 (wb=0111) followed by add rs1=3 -> stall_if_id=1 for exactly one cycle and ex_ctrl_wb=0 (bubble) that cycle; the add reaches EX the next cycle with fwd_a=01.
- Branch: beq in EX (m=3'b110) with ex_zero=1 -> pc_redirect=1 and flush_if_id=1 for one cycle, next ex_ctrl_m=0. The same beq with ex_zero=0 -> no redirect. bne (m=3'b100) inverts the outcome.
- Forward priority: add rd=4, add rd=4, then add rs1=4 rs2=4 -> fwd_a=fwd_b=10. With rd=0 throughout -> fwd=00.
- Simultaneous: lw rd=2 in EX that is also flagged as a taken branch (m=110), with ID rs1=2 -> redirect=1, flush=1, stall=0.

Source files
------------

// File: rtl/scpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scpu_ctrl_pkg: control-bundle widths, bit indices and select codes   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package scpu_ctrl_pkg;

    localparam int EX_W = 5;
    localparam int M_W  = 3;
    localparam int WB_W = 4;

    localparam int ALU_SRC_B = 4;
    localparam int BRANCH    = 2;
    localparam int B_TYPE    = 1;
    localparam int MEM_WRITE = 0;
    localparam int REG_WRITE = 2;

    localparam logic [1:0] MEM_TO_REG_ALU  = 2'b00;
    localparam logic [1:0] MEM_TO_REG_IMM  = 2'b01;
    localparam logic [1:0] MEM_TO_REG_PC4  = 2'b10;
    localparam logic [1:0] MEM_TO_REG_LOAD = 2'b11;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage
`default_nettype wire

// File: rtl/scpu_fwd_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scpu_fwd_unit: EX operand forwarding select for one source register  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scpu_fwd_unit
    import scpu_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] ex_rs,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            wb_reg_write,
    input  logic [RA_W-1:0] wb_rd,
    output logic [1:0]      fwd
);

    // The younger producer (EX/MEM) is checked first so it wins; x0 never forwards.
    always_comb begin
        fwd = FWD_RF;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            fwd = FWD_EXMEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            fwd = FWD_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scpu_ctrl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scpu_ctrl_pipe: ID/EX..MEM/WB control pipeline, hazards, forwarding  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scpu_ctrl_pipe
    import scpu_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [EX_W-1:0] id_ex,
    input  logic [M_W-1:0]  id_m,
    input  logic [WB_W-1:0] id_wb,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            ex_zero,
    output logic [EX_W-1:0] ex_ctrl_ex,
    output logic [M_W-1:0]  ex_ctrl_m,
    output logic [WB_W-1:0] ex_ctrl_wb,
    output logic [RA_W-1:0] ex_rd,
    output logic [M_W-1:0]  mem_ctrl_m,
    output logic [WB_W-1:0] mem_ctrl_wb,
    output logic [RA_W-1:0] mem_rd,
    output logic [WB_W-1:0] wb_ctrl_wb,
    output logic [RA_W-1:0] wb_rd,
    output logic            stall_if_id,
    output logic            flush_if_id,
    output logic            pc_redirect,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    logic [EX_W-1:0] r_ex_ex;
    logic [M_W-1:0]  r_ex_m;
    logic [WB_W-1:0] r_ex_wb;
    logic [RA_W-1:0] r_ex_rd;
    logic [RA_W-1:0] r_ex_rs1;
    logic [RA_W-1:0] r_ex_rs2;
    logic            r_ex_valid;
    logic [M_W-1:0]  r_mem_m;
    logic [WB_W-1:0] r_mem_wb;
    logic [RA_W-1:0] r_mem_rd;
    logic [WB_W-1:0] r_wb_wb;
    logic [RA_W-1:0] r_wb_rd;

    logic w_take;
    logic w_load_use;
    logic w_rs2_used;
    logic w_accept;

    assign w_take = r_ex_valid && r_ex_m[BRANCH] && (ex_zero == r_ex_m[B_TYPE]);

    // rs2 only matters when it is a register operand or the store data.
    assign w_rs2_used = !id_ex[ALU_SRC_B] || id_m[MEM_WRITE];
    assign w_load_use = r_ex_valid && (r_ex_wb[1:0] == MEM_TO_REG_LOAD) && (r_ex_rd != '0)
                     && ((r_ex_rd == id_rs1) || ((r_ex_rd == id_rs2) && w_rs2_used));

    assign w_accept    = id_valid && !w_take && !w_load_use;
    assign pc_redirect = w_take;
    assign flush_if_id = w_take;
    assign stall_if_id = w_load_use && !w_take;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_ex    <= '0;
            r_ex_m     <= '0;
            r_ex_wb    <= '0;
            r_ex_rd    <= '0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_ex_valid <= 1'b0;
            r_mem_m    <= '0;
            r_mem_wb   <= '0;
            r_mem_rd   <= '0;
            r_wb_wb    <= '0;
            r_wb_rd    <= '0;
        end else begin
            r_ex_ex    <= w_accept ? id_ex  : '0;
            r_ex_m     <= w_accept ? id_m   : '0;
            r_ex_wb    <= w_accept ? id_wb  : '0;
            r_ex_rd    <= w_accept ? id_rd  : '0;
            r_ex_rs1   <= w_accept ? id_rs1 : '0;
            r_ex_rs2   <= w_accept ? id_rs2 : '0;
            r_ex_valid <= w_accept;
            r_mem_m    <= r_ex_m;
            r_mem_wb   <= r_ex_wb;
            r_mem_rd   <= r_ex_rd;
            r_wb_wb    <= r_mem_wb;
            r_wb_rd    <= r_mem_rd;
        end
    end

    assign ex_ctrl_ex  = r_ex_ex;
    assign ex_ctrl_m   = r_ex_m;
    assign ex_ctrl_wb  = r_ex_wb;
    assign ex_rd       = r_ex_rd;
    assign mem_ctrl_m  = r_mem_m;
    assign mem_ctrl_wb = r_mem_wb;
    assign mem_rd      = r_mem_rd;
    assign wb_ctrl_wb  = r_wb_wb;
    assign wb_rd       = r_wb_rd;

    scpu_fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .ex_rs         (r_ex_rs1),
        .mem_reg_write (r_mem_wb[REG_WRITE]),
        .mem_rd        (r_mem_rd),
        .wb_reg_write  (r_wb_wb[REG_WRITE]),
        .wb_rd         (r_wb_rd),
        .fwd           (fwd_a)
    );

    scpu_fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .ex_rs         (r_ex_rs2),
        .mem_reg_write (r_mem_wb[REG_WRITE]),
        .mem_rd        (r_mem_rd),
        .wb_reg_write  (r_wb_wb[REG_WRITE]),
        .wb_rd         (r_wb_rd),
        .fwd           (fwd_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_scpu_ctrl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_scpu_ctrl_pipe: directed bench with an instruction-level model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_scpu_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_ex;
    logic [2:0] id_m;
    logic [3:0] id_wb;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_zero;
    logic [4:0] ex_ctrl_ex;
    logic [2:0] ex_ctrl_m;
    logic [3:0] ex_ctrl_wb;
    logic [4:0] ex_rd;
    logic [2:0] mem_ctrl_m;
    logic [3:0] mem_ctrl_wb;
    logic [4:0] mem_rd;
    logic [3:0] wb_ctrl_wb;
    logic [4:0] wb_rd;
    logic       stall_if_id, flush_if_id, pc_redirect;
    logic [1:0] fwd_a, fwd_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    scpu_ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ex(id_ex), .id_m(id_m),
        .id_wb(id_wb), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_ctrl_ex(ex_ctrl_ex), .ex_ctrl_m(ex_ctrl_m), .ex_ctrl_wb(ex_ctrl_wb), .ex_rd(ex_rd),
        .mem_ctrl_m(mem_ctrl_m), .mem_ctrl_wb(mem_ctrl_wb), .mem_rd(mem_rd),
        .wb_ctrl_wb(wb_ctrl_wb), .wb_rd(wb_rd), .stall_if_id(stall_if_id),
        .flush_if_id(flush_if_id), .pc_redirect(pc_redirect), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    // Instruction-level model: slot 0 = EX, 1 = MEM, 2 = WB; an all-zero entry is a bubble.
    typedef struct {
        logic       v;
        logic [4:0] ex;
        logic [2:0] m;
        logic [3:0] wb;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ins_t;

    ins_t pipe [3];

    function automatic ins_t bubble();
        ins_t b;
        b.v = 1'b0; b.ex = '0; b.m = '0; b.wb = '0; b.rd = '0; b.rs1 = '0; b.rs2 = '0;
        return b;
    endfunction

    function automatic logic m_take();
        return pipe[0].v && pipe[0].m[2] && (ex_zero == pipe[0].m[1]);
    endfunction

    function automatic logic m_load_use();
        ins_t e = pipe[0];
        if (!e.v || e.wb[1:0] != 2'b11 || e.rd == 5'd0) return 1'b0;
        if (e.rd == id_rs1) return 1'b1;
        return (e.rd == id_rs2) && (!id_ex[4] || id_m[0]);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        for (int i = 1; i <= 2; i++) begin
            if (pipe[i].wb[2] && pipe[i].rd != 5'd0 && pipe[i].rd == rs)
                return (i == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ins_t nx;
        logic tk, lu;
        tk = m_take();
        lu = m_load_use();
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] = bubble();
        end else begin
            nx = bubble();
            if (!tk && !lu && id_valid) begin
                nx.v = 1'b1; nx.ex = id_ex; nx.m = id_m; nx.wb = id_wb;
                nx.rd = id_rd; nx.rs1 = id_rs1; nx.rs2 = id_rs2;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nx;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic tk, lu;
            tk = m_take();
            lu = m_load_use();
            check("ex_ctrl_ex",  32'(ex_ctrl_ex),  32'(pipe[0].ex));
            check("ex_ctrl_m",   32'(ex_ctrl_m),   32'(pipe[0].m));
            check("ex_ctrl_wb",  32'(ex_ctrl_wb),  32'(pipe[0].wb));
            check("ex_rd",       32'(ex_rd),       32'(pipe[0].rd));
            check("mem_ctrl_m",  32'(mem_ctrl_m),  32'(pipe[1].m));
            check("mem_ctrl_wb", 32'(mem_ctrl_wb), 32'(pipe[1].wb));
            check("mem_rd",      32'(mem_rd),      32'(pipe[1].rd));
            check("wb_ctrl_wb",  32'(wb_ctrl_wb),  32'(pipe[2].wb));
            check("wb_rd",       32'(wb_rd),       32'(pipe[2].rd));
            check("pc_redirect", 32'(pc_redirect), 32'(tk));
            check("flush_if_id", 32'(flush_if_id), 32'(tk));
            check("stall_if_id", 32'(stall_if_id), 32'(lu && !tk));
            check("fwd_a",       32'(fwd_a),       32'(m_fwd(pipe[0].rs1)));
            check("fwd_b",       32'(fwd_b),       32'(m_fwd(pipe[0].rs2)));
        end
    end

    task automatic drive(input logic v, input logic [4:0] ex, input logic [2:0] m,
                         input logic [3:0] wb, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        id_valid = v; id_ex = ex; id_m = m; id_wb = wb;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 3'd0, 4'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = bubble();
        rst_n = 1'b0;
        ex_zero = 1'b0;
        drive(1'b1, 5'h1f, 3'b111, 4'hf, 5'd3, 5'd4, 5'd9);
        tick();
        chk_en = 1'b1;
        tick();
        neg();
        check("rst ex_ctrl_wb", 32'(ex_ctrl_wb), 32'h0);
        check("rst ex_ctrl_m",  32'(ex_ctrl_m),  32'h0);
        check("rst mem_rd",     32'(mem_rd),     32'h0);
        check("rst wb_ctrl_wb", 32'(wb_ctrl_wb), 32'h0);
        check("rst stall",      32'(stall_if_id), 32'h0);
        check("rst redirect",   32'(pc_redirect), 32'h0);
        rst_n = 1'b1;
        idle();
        tick();

        // addi rd=5 flows through
        drive(1'b1, 5'b10000, 3'b000, 4'b0100, 5'd1, 5'd0, 5'd5);
        tick(); idle();
        neg(); check("flow ex_rd", 32'(ex_rd), 32'd5);
        tick();
        neg(); check("flow mem_rd", 32'(mem_rd), 32'd5);
        tick();
        neg(); check("flow wb_ctrl_wb", 32'(wb_ctrl_wb), 32'b0100);
        tick();
        neg(); check("flow wb drained", 32'(wb_ctrl_wb), 32'h0);

        // lw rd=3, then add rs1=3: one stall cycle, then MEM/WB forward
        drive(1'b1, 5'b10000, 3'b000, 4'b0111, 5'd1, 5'd0, 5'd3);
        tick();
        drive(1'b1, 5'b00000, 3'b000, 4'b0100, 5'd3, 5'd6, 5'd7);
        neg(); check("lu stall", 32'(stall_if_id), 32'd1);
        tick();
        neg(); check("lu bubble wb", 32'(ex_ctrl_wb), 32'h0);
        check("lu stall once", 32'(stall_if_id), 32'd0);
        tick(); idle();
        neg(); check("lu add ex_rd", 32'(ex_rd), 32'd7);
        check("lu fwd_a", 32'(fwd_a), 32'b01);
        check("lu fwd_b", 32'(fwd_b), 32'b00);
        repeat (3) tick();

        // beq taken with wrong-path addi in ID
        drive(1'b1, 5'b00000, 3'b110, 4'b0000, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b1, 5'b10000, 3'b000, 4'b0100, 5'd1, 5'd0, 5'd9);
        ex_zero = 1'b1;
        neg(); check("beq redirect", 32'(pc_redirect), 32'd1);
        check("beq flush", 32'(flush_if_id), 32'd1);
        check("beq stall", 32'(stall_if_id), 32'd0);
        tick(); idle(); ex_zero = 1'b0;
        neg(); check("beq squash m", 32'(ex_ctrl_m), 32'h0);
        check("beq squash rd", 32'(ex_rd), 32'h0);
        tick();

        // beq not taken
        drive(1'b1, 5'b00000, 3'b110, 4'b0000, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b1, 5'b10000, 3'b000, 4'b0100, 5'd1, 5'd0, 5'd9);
        ex_zero = 1'b0;
        neg(); check("beq nt redirect", 32'(pc_redirect), 32'd0);
        tick(); idle();
        neg(); check("beq nt ex_rd", 32'(ex_rd), 32'd9);
        tick();

        // bne: taken when zero=0, not taken when zero=1
        drive(1'b1, 5'b00000, 3'b100, 4'b0000, 5'd1, 5'd2, 5'd0);
        tick(); idle(); ex_zero = 1'b0;
        neg(); check("bne taken", 32'(pc_redirect), 32'd1);
        tick();
        drive(1'b1, 5'b00000, 3'b100, 4'b0000, 5'd1, 5'd2, 5'd0);
        tick(); idle(); ex_zero = 1'b1;
        neg(); check("bne not taken", 32'(pc_redirect), 32'd0);
        tick(); ex_zero = 1'b0;
        repeat (2) tick();

        // forward priority: two producers of x4
        drive(1'b1, 5'b00000, 3'b000, 4'b0100, 5'd1, 5'd2, 5'd4);
        tick(); tick();
        drive(1'b1, 5'b00000, 3'b000, 4'b0100, 5'd4, 5'd4, 5'd8);
        tick(); idle();
        neg(); check("prio fwd_a", 32'(fwd_a), 32'b10);
        check("prio fwd_b", 32'(fwd_b), 32'b10);
        repeat (3) tick();

        // x0 never forwarded
        drive(1'b1, 5'b00000, 3'b000, 4'b0100, 5'd1, 5'd2, 5'd0);
        tick(); tick();
        drive(1'b1, 5'b00000, 3'b000, 4'b0100, 5'd0, 5'd0, 5'd0);
        tick(); idle();
        neg(); check("x0 fwd_a", 32'(fwd_a), 32'b00);
        check("x0 fwd_b", 32'(fwd_b), 32'b00);
        repeat (3) tick();

        // store after load: rs2 used as store data even with imm operand
        drive(1'b1, 5'b10000, 3'b000, 4'b0111, 5'd1, 5'd0, 5'd6);
        tick();
        drive(1'b1, 5'b10000, 3'b001, 4'b0000, 5'd1, 5'd6, 5'd0);
        neg(); check("sw lu stall", 32'(stall_if_id), 32'd1);
        tick(); tick(); idle();
        repeat (3) tick();

        // load that is also a taken branch, ID reads its rd
        drive(1'b1, 5'b10000, 3'b110, 4'b0111, 5'd1, 5'd0, 5'd2);
        tick();
        drive(1'b1, 5'b00000, 3'b000, 4'b0100, 5'd2, 5'd3, 5'd7);
        ex_zero = 1'b1;
        neg(); check("sim redirect", 32'(pc_redirect), 32'd1);
        check("sim flush", 32'(flush_if_id), 32'd1);
        check("sim stall", 32'(stall_if_id), 32'd0);
        tick(); idle(); ex_zero = 1'b0;
        tick();

        // reset mid-flight discards everything
        drive(1'b1, 5'b10000, 3'b000, 4'b0100, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 5'b10000, 3'b000, 4'b0100, 5'd1, 5'd0, 5'd6);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; idle();
        neg(); check("midrst ex_rd", 32'(ex_rd), 32'h0);
        check("midrst mem_rd", 32'(mem_rd), 32'h0);
        check("midrst wb_rd", 32'(wb_rd), 32'h0);
        repeat (4) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
